// File: rtl/instruction_fetch_unit_if.sv
// Bus between the instruction fetch unit and its surroundings: the control
// unit (Fetch/PCLoad/PCIn, InstrValid/FetchError/Busy/PC), byte-wide memory
// (MemAddr/MemRead in, MemData/MemReady back) and the instruction register
// (IRWrite/IRLH/IRData).
//
// Memory handshake: MemRead is the request and stays high, with MemAddr
// stable, for as long as the fetch unit waits on a byte. MemReady is the
// valid strobe for MemData. A byte transfers on any rising edge where
// MemRead and MemReady are both high. MemReady with MemRead low is ignored.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  Fetch;
  logic                  PCLoad;
  logic [ADDR_WIDTH-1:0] PCIn;
  logic [7:0]            MemData;
  logic                  MemReady;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic                  MemRead;
  logic                  IRWrite;
  logic                  IRLH;
  logic [7:0]            IRData;
  logic                  InstrValid;
  logic                  FetchError;
  logic                  Busy;
  logic [ADDR_WIDTH-1:0] PC;
  logic [2:0]            DbgState;

  // Fetch unit side.
  modport master (
    input  Fetch, PCLoad, PCIn, MemData, MemReady,
    output MemAddr, MemRead, IRWrite, IRLH, IRData,
           InstrValid, FetchError, Busy, PC, DbgState
  );

  // Environment side: control unit, memory and IR.
  modport slave (
    output Fetch, PCLoad, PCIn, MemData, MemReady,
    input  MemAddr, MemRead, IRWrite, IRLH, IRData,
           InstrValid, FetchError, Busy, PC, DbgState
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads a 16-bit instruction as two bytes (low byte
// at PC, high byte at PC+1) and steers each byte into the instruction
// register. Each byte waits up to TIMEOUT cycles for MemReady; on timeout
// the fetch is abandoned and PC is rewound to the instruction start so a
// retry refetches both bytes.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                     Clock,
  input  logic                     Reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } state_t;

  // Wait counter value on the last permitted cycle of a byte.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] start_pc;
  logic [7:0]            cnt;

  logic mem_read;
  logic ir_write;
  logic ir_lh;
  logic instr_valid;
  logic fetch_error;

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and output decode; outputs depend only on state and MemReady
  // so reset clears them immediately.
  always_comb begin
    state_n     = state;
    mem_read    = 1'b0;
    ir_write    = 1'b0;
    ir_lh       = 1'b0;
    instr_valid = 1'b0;
    fetch_error = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Fetch) state_n = FETCH_LO;
      end
      FETCH_LO: begin
        mem_read = 1'b1;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          state_n  = FETCH_HI;
        end else if (cnt == CNT_LAST) begin
          state_n = ERROR;
        end
      end
      FETCH_HI: begin
        mem_read = 1'b1;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          ir_lh    = 1'b1;
          state_n  = DONE;
        end else if (cnt == CNT_LAST) begin
          state_n = ERROR;
        end
      end
      DONE: begin
        instr_valid = 1'b1;
        state_n     = IDLE;
      end
      ERROR: begin
        fetch_error = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // PC, start address and per-byte wait counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc       <= RESET_PC;
      start_pc <= RESET_PC;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.PCLoad) pc <= bus.PCIn;
          // A jump target loaded in the same cycle is where this fetch starts.
          if (bus.Fetch) start_pc <= bus.PCLoad ? bus.PCIn : pc;
        end
        FETCH_LO, FETCH_HI: begin
          if (bus.MemReady) begin
            pc  <= pc + ADDR_WIDTH'(1);
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERROR: begin
          pc <= start_pc;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.MemAddr    = pc;
  assign bus.PC         = pc;
  assign bus.MemRead    = mem_read;
  assign bus.IRWrite    = ir_write;
  assign bus.IRLH       = ir_lh;
  assign bus.IRData     = bus.MemData;
  assign bus.InstrValid = instr_valid;
  assign bus.FetchError = fetch_error;
  assign bus.Busy       = (state != IDLE);
  assign bus.DbgState   = state;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the 16-bit instruction register.
- Reads one instruction as two bytes from byte-wide memory: low byte at PC, high byte at PC+1.
- Drives the IR's Write/LH/I inputs for each byte, advances the program counter, and reports completion to the control unit.
- Handles variable memory latency through a ready handshake and aborts the fetch if memory does not answer in time.

Parameters:
- ADDR_WIDTH, 16, width of PC and memory address.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, max cycles to wait for MemReady per byte before error (1..255).

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset.
- Fetch  input  1  request to fetch the next instruction; sampled only in IDLE.
- PCLoad  input  1  load PC from PCIn; honoured only in IDLE.
- PCIn  input  ADDR_WIDTH  new PC value (jump/branch target).
- MemData  input  8  byte returned by memory.
- MemReady  input  1  MemData valid this cycle.
- MemAddr  output  ADDR_WIDTH  byte address; registered, equals PC.
- MemRead  output  1  memory read request.
- IRWrite  output  1  to IR Write.
- IRLH  output  1  to IR LH; 0 = low byte, 1 = high byte.
- IRData  output  8  to IR I; combinational pass-through of MemData.
- InstrValid  output  1  one-cycle pulse: IR holds the complete new instruction.
- FetchError  output  1  one-cycle pulse: fetch aborted on timeout.
- Busy  output  1  high in every state except IDLE.
- PC  output  ADDR_WIDTH  current program counter.

Behaviour:
- Reset (Reset=0, asynchronous, any state):
  - state=IDLE; PC=RESET_PC; wait counter=0; all 1-bit outputs=0.
  - A fetch interrupted mid-operation is discarded; the IR may hold a partial instruction and InstrValid is not pulsed.
- State encoding: IDLE, FETCH_LO, FETCH_HI, DONE, ERROR. Register holding the start address: StartPC.
- IDLE:
  - If PCLoad=1, PC<=PCIn.
  - If Fetch=1, StartPC<=PC (or PCIn when PCLoad=1 in the same cycle) and next state is FETCH_LO. Simultaneous PCLoad+Fetch therefore fetches from PCIn.
- FETCH_LO:
  - MemRead=1; MemAddr=PC.
  - If MemReady=1: IRWrite=1, IRLH=0, IRData=MemData (IR captures on the same edge); PC<=PC+1; counter<=0; next FETCH_HI.
  - Else counter<=counter+1. When counter reaches TIMEOUT-1 without MemReady, next ERROR.
- FETCH_HI: same as FETCH_LO with IRLH=1. On MemReady: PC<=PC+1, next DONE.
- DONE: InstrValid=1 for exactly one cycle; next IDLE. Fetch is ignored in DONE.
- ERROR: FetchError=1 for one cycle; PC<=StartPC, so a retry refetches the whole instruction; next IDLE.
- Outputs in non-fetch states: IRWrite=0 and MemRead=0 outside FETCH_LO/FETCH_HI. IRLH=0 when IRWrite=0.
- Arithmetic: PC increments modulo 2^ADDR_WIDTH; all-ones wraps to 0, including between the two bytes of one instruction.
- Latency: with MemReady tied high, Fetch sampled at edge N gives IR writes at edges N+1 and N+2 and InstrValid high during cycle N+3. Minimum 4 cycles per instruction, including the return to IDLE.
- PCLoad outside IDLE: ignored; PC is not disturbed.
- MemReady outside fetch states: ignored.

Test Plan:
- Reset, MemReady=1, memory[0]=0x34, memory[1]=0x12, pulse Fetch -> IRWrite with IRLH=0 and IRData=0x34, next cycle IRWrite with IRLH=1 and IRData=0x12; InstrValid one cycle later; IR=0x1234; PC=2.
- PCLoad=1 with PCIn=0x0100 and Fetch=1 in the same IDLE cycle -> MemAddr=0x0100 then 0x0101; PC=0x0102 after DONE.
- PCIn=0xFFFF, fetch -> low byte read at 0xFFFF, high byte at 0x0000; final PC=0x0001.
- MemReady held low 3 cycles per byte -> IRWrite only on MemReady cycles; InstrValid after both bytes; Busy=1 throughout.
- Low byte succeeds at PC=0x0010, MemReady never returns for the high byte -> FetchError pulses after TIMEOUT=15 cycles; PC=0x0010; InstrValid never asserted; next Fetch restarts at 0x0010.
- Reset asserted during FETCH_HI -> outputs 0 and PC=RESET_PC immediately (asynchronous); no InstrValid.
